// File: rtl/jtag_flush_sequencer.sv
// JTAG master: resets the TAP, loads IR, shifts a flush pattern through DR and
// checks that it comes back on TDO after CHAIN_LEN TCK cycles.
module jtag_flush_sequencer #(
  parameter int IR_WIDTH  = 4,
  parameter int PAT_WIDTH = 5,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [IR_WIDTH-1:0]  IR_CODE,
  input  logic [PAT_WIDTH-1:0] PATTERN,
  input  logic [CNT_W-1:0]     CHAIN_LEN,
  input  logic                 TDO_I,
  output logic                 TCK_O,
  output logic                 TMS_O,
  output logic                 TDI_O,
  output logic                 TRSTN_O,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic                 ERR,
  output logic [PAT_WIDTH-1:0] RX_PAT
);
  localparam int MAX_LEN = (1 << CNT_W) - 1 - PAT_WIDTH;

  // Declaration order is the TAP walk order; the successor is state+1.
  typedef enum logic [3:0] {
    IDLE, RESET_TAP, RTI, SEL_DR, SEL_IR, CAP_IR, TO_SHIFT_IR, SHIFT_IR,
    UPD_IR, SEL_DR2, CAP_DR, TO_SHIFT_DR, SHIFT_DR, UPD_DR, END_RTI, FIN
  } state_t;

  state_t               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IR_WIDTH-1:0]  ir_q;
  logic [PAT_WIDTH-1:0] pat_q;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     n_last;
  logic [PAT_WIDTH-1:0] rx_nxt;
  logic                 last, len_bad, accept, ld, tms_d, tdi_d;

  assign len_bad = (CHAIN_LEN == '0) || (CHAIN_LEN > CNT_W'(MAX_LEN));
  assign accept  = (state_q == IDLE) && START;
  assign n_last  = len_q + CNT_W'(PAT_WIDTH - 1);
  assign rx_nxt  = PAT_WIDTH'({TDO_I, RX_PAT} >> 1);
  assign TCK_O   = phase_q;

  always_comb begin
    case (state_q)
      RESET_TAP: last = (cnt_q == CNT_W'(4));
      SHIFT_IR:  last = (cnt_q == CNT_W'(IR_WIDTH - 1));
      SHIFT_DR:  last = (cnt_q == n_last);
      default:   last = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // A TAP cycle advances only at the end of phase1 (TCK falling edge).
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = len_bad ? FIN : RESET_TAP;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
      FIN: state_d = IDLE;
      default: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (last) begin
            state_d = state_t'(state_q + 4'd1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // TMS/TDI for the TAP cycle about to begin, registered on phase0 entry.
  always_comb begin
    tms_d = TMS_O;
    tdi_d = 1'b0;
    case (state_d)
      RESET_TAP, SEL_DR, SEL_IR, UPD_IR, SEL_DR2, UPD_DR: tms_d = 1'b1;
      RTI, CAP_IR, TO_SHIFT_IR, CAP_DR, TO_SHIFT_DR, END_RTI: tms_d = 1'b0;
      SHIFT_IR: begin
        tms_d = (cnt_d == CNT_W'(IR_WIDTH - 1));
        tdi_d = |(ir_q & (IR_WIDTH'(1) << cnt_d));
      end
      SHIFT_DR: begin
        tms_d = (cnt_d == n_last);
        tdi_d = |(pat_q & (PAT_WIDTH'(1) << cnt_d));
      end
      default: ;
    endcase
    BUSY = (state_q != IDLE) && (state_q != FIN);
    DONE = (state_q == FIN);
    ld   = (accept && !len_bad) || (BUSY && phase_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      TMS_O   <= 1'b1;
      TDI_O   <= 1'b0;
      TRSTN_O <= 1'b0;
      PASS    <= 1'b0;
      ERR     <= 1'b0;
      RX_PAT  <= '0;
      ir_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      TRSTN_O <= 1'b1;
      if (accept) begin
        ir_q   <= IR_CODE;
        pat_q  <= PATTERN;
        len_q  <= CHAIN_LEN;
        PASS   <= 1'b0;
        ERR    <= len_bad;
        RX_PAT <= '0;
      end
      if (ld) begin
        TMS_O <= tms_d;
        TDI_O <= tdi_d;
      end
      // Samples k >= L shift in from the top so sample L lands in bit 0.
      if (state_q == SHIFT_DR && phase_q) begin
        if (cnt_q >= len_q) RX_PAT <= rx_nxt;
        if (last) PASS <= (rx_nxt == pat_q);
      end
    end
  end
endmodule

// File: doc/jtag_flush_sequencer.md
Name: jtag_flush_sequencer

Overview:
- Synthesizable, parametrised JTAG master that drives a boundary-scan/scan-chain TAP through a complete flush test: TAP reset, IR load, DR shift of a pattern, then a check that the pattern emerges on TDO after the chain delay.
- Replaces the hand-sequenced TMS/TDI bench stimulus with reusable on-chip or bench-side logic, generalised in IR width, pattern width and chain length.
- Reports pass/fail and the captured pattern.
- Sits between the system clock domain and the TAP pins of the GCD TOP (TCK/TMS/TDI/TDO/TRSTN).

Parameters:
- IR_WIDTH, 4, instruction register length in bits.
- PAT_WIDTH, 5, flush pattern length in bits.
- CNT_W, 8, width of the chain_len and shift counters; max chain length is 2^CNT_W-1-PAT_WIDTH.

Ports:
- CLK  input  1  system clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- IR_CODE  input  IR_WIDTH  instruction to load; LSB shifted first.
- PATTERN  input  PAT_WIDTH  flush pattern; LSB shifted first.
- CHAIN_LEN  input  CNT_W  expected chain length L between TDI and TDO.
- TDO_I  input  1  TAP TDO.
- TCK_O  output  1  generated TAP clock, CLK/2.
- TMS_O  output  1  TAP TMS.
- TDI_O  output  1  TAP TDI.
- TRSTN_O  output  1  TAP reset, active low.
- BUSY  output  1  high from START acceptance until DONE.
- DONE  output  1  one-CLK pulse at the end of a run.
- PASS  output  1  result; valid when DONE is high, held until the next START.
- ERR  output  1  illegal request flag (CHAIN_LEN==0); held until the next START.
- RX_PAT  output  PAT_WIDTH  captured TDO bits; sample L+j goes to bit j.

Behaviour:
- Reset (synchronous, any state including mid-run):
  - TCK_O=0, TMS_O=1, TDI_O=0, TRSTN_O=0, BUSY=0, DONE=0, PASS=0, ERR=0, RX_PAT=0.
  - FSM goes to IDLE and the phase is cleared.
  - TRSTN_O goes to 1 on the first clock after RST deasserts.
- Inputs IR_CODE, PATTERN and CHAIN_LEN are latched on START acceptance. START while BUSY is ignored.
- CHAIN_LEN==0 at START: no TAP activity. Next clock: DONE=1, ERR=1, PASS=0, BUSY stays 0.
- TAP cycle timing:
  - Each TAP cycle is 2 CLK: phase0 TCK_O=0, phase1 TCK_O=1.
  - TMS_O and TDI_O update only on entry to phase0 (TCK falling edge).
  - TDO_I is sampled on the CLK edge that ends phase1, and only during Shift-DR cycles.
- FSM states and the TMS value driven during each TAP cycle:
  - RESET_TAP: 5 cycles, TMS=1.
  - RTI: 1 cycle, TMS=0.
  - SEL_DR: TMS=1.
  - SEL_IR: TMS=1.
  - CAP_IR: TMS=0.
  - TO_SHIFT_IR: TMS=0.
  - SHIFT_IR: IR_WIDTH cycles, TDI=IR_CODE[i], TMS=0 except 1 on the last bit.
  - UPD_IR: TMS=1.
  - SEL_DR2: TMS=1.
  - CAP_DR: TMS=0.
  - TO_SHIFT_DR: TMS=0.
  - SHIFT_DR: N=L+PAT_WIDTH cycles. TDI=PATTERN[k] for k<PAT_WIDTH, else 0. TMS=0 except 1 on the last cycle.
  - UPD_DR: TMS=1.
  - END_RTI: TMS=0.
  - Then DONE, then IDLE.
- TDI_O=0 in all non-shift cycles.
- Total TAP cycles T = 16+IR_WIDTH+N.
- Latency: DONE rises exactly 2T+1 CLK after the START cycle. BUSY falls in the same cycle DONE rises.
- Capture and check:
  - Shift-DR sample index k = 0..N-1.
  - For k>=L, TDO_I is stored into RX_PAT[k-L].
  - PASS = (RX_PAT == latched PATTERN) at the end of SHIFT_DR.
- Counters: shift counter is CNT_W bits with no wrap. CHAIN_LEN > 2^CNT_W-1-PAT_WIDTH is illegal and sets ERR the same as 0.
- After DONE, the TAP is left in Run-Test/Idle with TMS_O=0 and TCK_O=0.

Test Plan:
- RST held 3 CLK mid-SHIFT_DR -> next clock: all outputs at reset values, TRSTN_O=0. One clock after RST drops, TRSTN_O=1, BUSY=0.
- Loopback model (3-bit shift register on TCK_O rise), IR_CODE=4'b1101, PATTERN=5'b11001, CHAIN_LEN=3:
  - TDI during SHIFT_IR reads 1,0,1,1.
  - DONE exactly 57 CLK after START (T=28).
  - PASS=1, RX_PAT=5'b11001.
- Same setup but model length 4, CHAIN_LEN=3 -> PASS=0, RX_PAT=5'b10010.
- CHAIN_LEN=0 -> DONE on the next clock, ERR=1, PASS=0, TCK_O stays 0 throughout.
- TMS_O trace check against the FSM sequence: 1,1,1,1,1,0,1,1,0,0,0,0,0,1,1,1,0,0, then N-1 zeros, then 1,1,0. Second START pulsed while BUSY -> ignored, no extra DONE.
- Stuck-at-0 TDO with PATTERN=5'b00000 -> PASS=1; with PATTERN=5'b00001 -> PASS=0.
